uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter between G_N_REQ requesters (e.g. several 9x8 processor outports or status sources feeding the single o_UART_Tx line).
- Round-robin arbitration at message granularity: once granted, a requester owns the transmitter until it presents its last byte, so messages are never interleaved.
- A stall timeout releases an owner that stops supplying bytes mid-message.
- Sits between the requesters and the UART Tx serializer; paces byte writes using the serializer busy flag.

Parameters:
G_N_REQ, 4, number of requesters (2..8).
G_TIMEOUT, 1000, clock cycles an owner may hold the grant with i_req_valid low before forced release; 0 disables the timeout.

Ports:
i_clk  in  1  processor clock.
i_rst  in  1  asynchronous, active-high reset.
i_req_valid  in  G_N_REQ  per-requester byte valid.
i_req_data  in  8*G_N_REQ  per-requester byte; requester k uses bits [8k+:8].
i_req_last  in  G_N_REQ  per-requester end-of-message flag, qualified by valid.
o_req_ready  out  G_N_REQ  per-requester byte accept.
o_grant  out  G_N_REQ  one-hot current owner; 0 when idle.
o_tx_data  out  8  byte to the serializer.
o_tx_wr  out  1  one-cycle write strobe to the serializer.
i_tx_busy  in  1  serializer busy; it must assert no later than the cycle after o_tx_wr.
o_timeout  out  1  one-cycle pulse when an owner is force-released.

Behaviour:
- Reset (asynchronous) forces: state IDLE; o_grant, o_req_ready, o_tx_wr, o_timeout and o_tx_data all 0; round-robin pointer to 0; timeout counter to 0.
- Reset asserted mid-message deasserts o_tx_wr immediately. Any byte not yet strobed is dropped. After reset the transmitter line state is the serializer's responsibility.
- States: IDLE, OWN, GAP.
- IDLE:
  - If any i_req_valid is high at cycle t, select the first valid requester searching upward (with wrap) from the pointer.
  - o_grant is registered at t+1; state goes to OWN.
  - No byte is accepted in cycle t.
- OWN:
  - o_req_ready[k] = o_grant[k] AND NOT i_tx_busy. This is combinational from the registered grant, state and i_tx_busy.
  - An accepted byte (valid AND ready) is registered into o_tx_data, and o_tx_wr pulses in the next cycle. State goes to GAP.
- GAP:
  - Lasts exactly 2 cycles: the o_tx_wr cycle and the following cycle.
  - i_tx_busy is ignored and ready is 0.
  - Then return to OWN, or to IDLE if the accepted byte carried last.
- Release on last:
  - The pointer is set to owner+1 (mod G_N_REQ), so other waiting requesters win before the same requester wins again.
  - o_grant clears in the same cycle the state enters IDLE.
- Timeout:
  - The counter increments in OWN each cycle the owner's valid is low; it clears on every accepted byte and on grant.
  - When the count reaches G_TIMEOUT: release as for last (pointer = owner+1), pulse o_timeout for 1 cycle, go to IDLE.
  - An owner holding valid high while i_tx_busy is high does not time out.
- Non-owner valid inputs are ignored while a grant is held; non-owner ready is always 0.
- Minimum byte spacing is therefore 3 cycles plus the serializer busy time. Throughput is bounded by the serializer, not the arbiter.
- Single-byte message (valid and last together on the first byte): grant, accept, strobe, then IDLE after GAP.
- o_grant is always one-hot or zero.

Test Plan:
- Single requester: requester 0 sends 0x48,0x69,last 0x0A with a busy model of 10 cycles -> three o_tx_wr pulses with data 0x48,0x69,0x0A in order; o_grant returns to 0 after the GAP that follows 0x0A.
- Round-robin: requesters 1 and 3 both assert valid from reset, each with a 2-byte message -> requester 1 is granted first and completes both bytes, then requester 3. Repeat the request pair -> requester 3 is not skipped and the pointer wraps correctly.
- No interleaving: requester 0 owns the grant mid-message while requester 2 asserts valid -> o_req_ready[2] stays 0 until requester 0's last byte has passed GAP; no requester 2 byte appears between requester 0's bytes.
- Timeout: with G_TIMEOUT=16, requester 0 sends one non-last byte and drops valid -> o_timeout pulses exactly 16 cycles after the counter starts; o_grant clears; waiting requester 1 is granted on the next cycle.
- Busy pacing: hold i_tx_busy high for 50 cycles after a write -> ready stays 0 for the whole busy period; the next byte is accepted in the first cycle busy is low.
- Async reset mid-message: assert i_rst between edges during GAP -> o_tx_wr, o_grant and o_req_ready go 0 without waiting for a clock edge. After release, requester 0 wins from the pointer-0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one byte-wide UART transmitter
// between G_N_REQ requesters, with serializer pacing and a stalled-owner timeout.
module uart_tx_arbiter #(
  parameter int unsigned G_N_REQ   = 4,
  parameter int unsigned G_TIMEOUT = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [G_N_REQ-1:0]   i_req_valid,
  input  logic [8*G_N_REQ-1:0] i_req_data,
  input  logic [G_N_REQ-1:0]   i_req_last,
  output logic [G_N_REQ-1:0]   o_req_ready,
  output logic [G_N_REQ-1:0]   o_grant,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_wr,
  input  logic                 i_tx_busy,
  output logic                 o_timeout
);

  localparam int unsigned PW    = (G_N_REQ < 2) ? 1 : $clog2(G_N_REQ);
  localparam int unsigned CW    = (G_TIMEOUT < 2) ? 1 : $clog2(G_TIMEOUT + 1);
  localparam logic        TO_EN = (G_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [G_N_REQ-1:0] grant_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      ptr_release;
  logic [PW-1:0]      sel_idx;
  logic               sel_found;
  logic [PW:0]        cand;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW:0]        cnt_inc;
  logic               gap_q, gap_d;
  logic               last_q, last_d;
  logic [7:0]         tx_data_d;
  logic [7:0]         owner_data;
  logic               tx_wr_d;
  logic               timeout_d;
  logic               owner_valid;
  logic               owner_last;
  logic               accept;

  // First valid requester searching upward from the pointer, with wrap
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < G_N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(G_N_REQ)) begin
        cand = cand - (PW+1)'(G_N_REQ);
      end
      if (!sel_found && i_req_valid[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  // Byte of the current owner
  always_comb begin
    owner_data = '0;
    for (int unsigned k = 0; k < G_N_REQ; k++) begin
      if (owner_q == PW'(k)) begin
        owner_data = i_req_data[8*k +: 8];
      end
    end
  end

  assign owner_valid = |(i_req_valid & o_grant);
  assign owner_last  = |(i_req_last & o_grant);
  assign o_req_ready = ((state_q == OWN) && !i_tx_busy) ? o_grant : '0;
  assign accept      = (state_q == OWN) && !i_tx_busy && owner_valid;
  assign ptr_release = (owner_q == PW'(G_N_REQ - 1)) ? '0 : owner_q + PW'(1);
  assign cnt_inc     = {1'b0, cnt_q} + (CW+1)'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = o_grant;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    last_d    = last_q;
    tx_data_d = o_tx_data;
    tx_wr_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = OWN;
          grant_d = G_N_REQ'(1) << sel_idx;
          owner_d = sel_idx;
          cnt_d   = '0;
        end
      end

      OWN: begin
        if (accept) begin
          tx_data_d = owner_data;
          tx_wr_d   = 1'b1;
          last_d    = owner_last;
          gap_d     = 1'b0;
          cnt_d     = '0;
          state_d   = GAP;
        end else if (!owner_valid) begin
          // Owner went quiet mid-message: count toward forced release
          if (TO_EN && (cnt_inc == (CW+1)'(G_TIMEOUT))) begin
            state_d   = IDLE;
            grant_d   = '0;
            ptr_d     = ptr_release;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (TO_EN) begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
      end

      GAP: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if (last_q) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_release;
        end else begin
          state_d = OWN;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      o_grant   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= 1'b0;
      last_q    <= 1'b0;
      o_tx_data <= '0;
      o_tx_wr   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_grant   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      last_q    <= last_d;
      o_tx_data <= tx_data_d;
      o_tx_wr   <= tx_wr_d;
      o_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of expected transmitter writes per
// message group, plus hand sequences for busy pacing, async reset and timeout.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_wr;
  logic           tx_busy;
  logic           timeout;

  uart_tx_arbiter #(
    .G_N_REQ  (N),
    .G_TIMEOUT(TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_grant    (grant),
    .o_tx_data  (tx_data),
    .o_tx_wr    (tx_wr),
    .i_tx_busy  (tx_busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         grp;
    int         src;
    logic [7:0] data;
    logic       last;
    logic [3:0] exp_grant;
  } vec_t;

  vec_t       tbl [20];
  logic [8:0] src_q [N][$];
  logic [7:0] wr_data [$];
  logic [3:0] wr_grant [$];
  int         wr_cyc [$];
  int         to_cyc [$];
  logic [3:0] grant_hist [0:8191];

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         viol = 0;
  int         busy_len = 3;
  int         busy_cnt = 0;
  logic [3:0] fire;
  logic       tx_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic queues_empty();
    logic e;
    e = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic drive_inputs();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() != 0) begin
        v[k]        = 1'b1;
        d[8*k +: 8] = src_q[k][0][7:0];
        l[k]        = src_q[k][0][8];
      end
    end
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  // Mid-cycle observation of outputs and protocol invariants
  task automatic sample_phase();
    @(negedge clk);
    fire    = req_valid & req_ready;
    tx_seen = tx_wr;
    if (cyc < 8192) grant_hist[cyc] = grant;
    if (tx_wr) begin
      wr_data.push_back(tx_data);
      wr_grant.push_back(grant);
      wr_cyc.push_back(cyc);
    end
    if (timeout) to_cyc.push_back(cyc);
    if ((req_ready & ~grant) != '0) viol++;
    if (tx_busy && (req_ready != '0)) viol++;
    if (!$onehot0(grant)) viol++;
  endtask

  // Clock edge: retire accepted bytes, step the serializer model, drive next inputs
  task automatic advance_phase();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (fire[k] && (src_q[k].size() != 0)) src_q[k].delete(0);
    end
    if (tx_seen) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt != 0);
    drive_inputs();
  endtask

  task automatic step();
    sample_phase();
    advance_phase();
  endtask

  task automatic run_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!queues_empty() && (n < budget)) begin
      step();
      n++;
    end
    check({name, " drained"}, 32'(queues_empty()), 32'd1);
    repeat (4) step();
  endtask

  task automatic load_group(input int g);
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].grp == g) src_q[tbl[i].src].push_back({tbl[i].last, tbl[i].data});
    end
    drive_inputs();
  endtask

  task automatic check_group(input int g, input int base);
    int j;
    int nrows;
    int c;
    j     = base;
    nrows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].grp == g) begin
        nrows++;
        if (j < wr_data.size()) begin
          check($sformatf("g%0d wr%0d data", g, j - base), 32'(wr_data[j]), 32'(tbl[i].data));
          check($sformatf("g%0d wr%0d grant", g, j - base), 32'(wr_grant[j]), 32'(tbl[i].exp_grant));
          c = wr_cyc[j] + 2;
          if (c < 8192)
            check($sformatf("g%0d wr%0d grant after gap", g, j - base), 32'(grant_hist[c]),
                  tbl[i].last ? 32'd0 : 32'(tbl[i].exp_grant));
        end
        j++;
      end
    end
    check($sformatf("g%0d write count", g), 32'(wr_data.size() - base), 32'(nrows));
  endtask

  initial begin
    int  base;
    int  to_base;
    int  t;
    int  w;
    logic found;

    // Rows of a group are listed in the order the transmitter must see them
    tbl[0]  = '{0, 1, 8'h11, 1'b0, 4'b0010};
    tbl[1]  = '{0, 1, 8'h12, 1'b1, 4'b0010};
    tbl[2]  = '{0, 3, 8'h31, 1'b0, 4'b1000};
    tbl[3]  = '{0, 3, 8'h32, 1'b1, 4'b1000};
    tbl[4]  = '{1, 1, 8'h13, 1'b0, 4'b0010};
    tbl[5]  = '{1, 1, 8'h14, 1'b1, 4'b0010};
    tbl[6]  = '{1, 3, 8'h33, 1'b0, 4'b1000};
    tbl[7]  = '{1, 3, 8'h34, 1'b1, 4'b1000};
    tbl[8]  = '{2, 0, 8'h48, 1'b0, 4'b0001};
    tbl[9]  = '{2, 0, 8'h69, 1'b0, 4'b0001};
    tbl[10] = '{2, 0, 8'h0A, 1'b1, 4'b0001};
    tbl[11] = '{3, 1, 8'hB0, 1'b1, 4'b0010};
    tbl[12] = '{3, 2, 8'hC0, 1'b0, 4'b0100};
    tbl[13] = '{3, 2, 8'hC1, 1'b1, 4'b0100};
    tbl[14] = '{3, 0, 8'hA0, 1'b1, 4'b0001};
    tbl[15] = '{4, 0, 8'h55, 1'b0, 4'b0001};
    tbl[16] = '{4, 0, 8'h56, 1'b1, 4'b0001};
    tbl[17] = '{5, 1, 8'hD1, 1'b1, 4'b0010};
    tbl[18] = '{6, 0, 8'hF0, 1'b1, 4'b0001};
    tbl[19] = '{6, 2, 8'hF2, 1'b1, 4'b0100};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    fire      = '0;
    tx_seen   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset ready", 32'(req_ready), 32'd0);
    check("reset tx_wr", 32'(tx_wr), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();
    repeat (2) step();

    // Round robin from reset, then the same pair again
    for (int g = 0; g < 2; g++) begin
      busy_len = 3;
      base = wr_data.size();
      load_group(g);
      run_drain($sformatf("g%0d", g), 300);
      check_group(g, base);
    end

    // Single requester, 10-cycle serializer
    busy_len = 10;
    base = wr_data.size();
    load_group(2);
    run_drain("g2", 300);
    check_group(2, base);
    if (wr_data.size() >= base + 3) begin
      check("g2 spacing 1", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd12);
      check("g2 spacing 2", 32'(wr_cyc[base+2] - wr_cyc[base+1]), 32'd12);
    end

    // Three contenders, pointer at 1, single- and multi-byte messages
    busy_len = 3;
    base = wr_data.size();
    load_group(3);
    run_drain("g3", 300);
    check_group(3, base);

    // Long busy: owner holds valid, no acceptance and no timeout while busy
    busy_len = 50;
    base = wr_data.size();
    load_group(4);
    run_drain("g4", 400);
    check_group(4, base);
    if (wr_data.size() >= base + 2)
      check("g4 busy spacing", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd52);

    // Leave the pointer at 2 before the reset test
    busy_len = 3;
    base = wr_data.size();
    load_group(5);
    run_drain("g5", 300);
    check_group(5, base);

    // Async reset asserted between edges during the write cycle of a message
    src_q[0].push_back({1'b0, 8'hE0});
    src_q[0].push_back({1'b1, 8'hE1});
    drive_inputs();
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      sample_phase();
      if (tx_wr) begin
        found = 1'b1;
        break;
      end
      advance_phase();
    end
    check("rst first write seen", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst tx_wr", 32'(tx_wr), 32'd0);
    check("async rst grant", 32'(grant), 32'd0);
    check("async rst ready", 32'(req_ready), 32'd0);
    check("async rst tx_data", 32'(tx_data), 32'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    advance_phase();
    busy_cnt = 0;
    tx_busy  = 1'b0;
    rst      = 1'b0;
    repeat (2) step();
    base = wr_data.size();
    load_group(6);
    run_drain("g6", 300);
    check_group(6, base);

    // Stalled owner: one non-last byte then valid drops; requester 1 waits
    busy_len = 2;
    base     = wr_data.size();
    to_base  = to_cyc.size();
    check("no timeout before stall test", 32'(to_base), 32'd0);
    src_q[0].push_back({1'b0, 8'h77});
    src_q[1].push_back({1'b1, 8'h99});
    drive_inputs();
    run_drain("timeout", 300);
    check("timeout write count", 32'(wr_data.size() - base), 32'd2);
    check("timeout pulses", 32'(to_cyc.size() - to_base), 32'd1);
    if ((wr_data.size() >= base + 2) && (to_cyc.size() > to_base)) begin
      check("timeout wr0 data", 32'(wr_data[base]), 32'h77);
      check("timeout wr1 data", 32'(wr_data[base+1]), 32'h99);
      check("timeout wr1 grant", 32'(wr_grant[base+1]), 32'b0010);
      w = wr_cyc[base];
      t = to_cyc[to_base];
      check("timeout cycle", 32'(t - w), 32'd18);
      if ((t > 0) && (t + 1 < 8192)) begin
        check("grant before timeout", 32'(grant_hist[t-1]), 32'b0001);
        check("grant at timeout", 32'(grant_hist[t]), 32'd0);
        check("grant after timeout", 32'(grant_hist[t+1]), 32'b0010);
      end
    end

    check("protocol violations", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", tests);
    $fatal(1, "watchdog");
  end

endmodule
